hue_ramp: RTL

HUE_RAMP -- requirements
Module: hue_ramp

---
 rtl/hue_pkg.sv | 38 +++
 rtl/hue_ramp_step_timer.sv | 19 +
 rtl/hue_ramp.sv | 67 ++++++
 3 files changed

// File: rtl/hue_pkg.sv
// hue_pkg: hue phase encoding, phase sequencing and per-phase channel selects
package hue_pkg;
  typedef enum logic [2:0] {
    GREEN_INC = 3'd0,
    RED_DEC   = 3'd1,
    BLUE_INC  = 3'd2,
    GREEN_DEC = 3'd3,
    RED_INC   = 3'd4,
    BLUE_DEC  = 3'd5
  } phase_e;

  localparam logic [1:0] CH_ZERO = 2'd0;
  localparam logic [1:0] CH_FULL = 2'd1;
  localparam logic [1:0] CH_UP   = 2'd2;
  localparam logic [1:0] CH_DN   = 2'd3;

  localparam logic [5:0] SEL_GREEN_INC = {CH_FULL, CH_UP,   CH_ZERO};
  localparam logic [5:0] SEL_RED_DEC   = {CH_DN,   CH_FULL, CH_ZERO};
  localparam logic [5:0] SEL_BLUE_INC  = {CH_ZERO, CH_FULL, CH_UP};
  localparam logic [5:0] SEL_GREEN_DEC = {CH_ZERO, CH_DN,   CH_FULL};
  localparam logic [5:0] SEL_RED_INC   = {CH_UP,   CH_ZERO, CH_FULL};
  localparam logic [5:0] SEL_BLUE_DEC  = {CH_FULL, CH_ZERO, CH_DN};

  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    return (ph >= BLUE_DEC) ? GREEN_INC : ph + 3'd1;
  endfunction

  function automatic logic [5:0] chan_sel(input logic [2:0] ph);
    case (ph)
      RED_DEC:   return SEL_RED_DEC;
      BLUE_INC:  return SEL_BLUE_INC;
      GREEN_DEC: return SEL_GREEN_DEC;
      RED_INC:   return SEL_RED_INC;
      BLUE_DEC:  return SEL_BLUE_DEC;
      default:   return SEL_GREEN_INC;
    endcase
  endfunction
endpackage

// File: rtl/hue_ramp_step_timer.sv
// step_timer: ticks every STEP_INTERVAL running cycles, parks on the last count while held
module step_timer #(
  parameter int STEP_INTERVAL = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic hold,
  output logic tick
);
  localparam int CW = $clog2(STEP_INTERVAL + 1);
  localparam logic [CW-1:0] LAST = CW'(STEP_INTERVAL - 1);
  logic [CW-1:0] cnt;
  assign tick = run && !hold && cnt == LAST;
  // advance while running; a held tick waits on LAST so no step is lost
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (run) cnt <= tick ? '0 : (cnt == LAST ? cnt : cnt + 1'b1);
endmodule

// File: rtl/hue_ramp.sv
// hue_ramp: six-phase RGB hue ramp producing duty triples over a valid/ready handshake
module hue_ramp
  import hue_pkg::*;
#(
  parameter int PWM_INTERVAL  = 1200,
  parameter int DUTY_STEP     = 6,
  parameter int STEP_INTERVAL = 10000,
  localparam int W = $clog2(PWM_INTERVAL + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  output logic [W-1:0] duty_r,
  output logic [W-1:0] duty_g,
  output logic [W-1:0] duty_b,
  output logic         duty_valid,
  input  logic         duty_ready,
  output logic [2:0]   phase,
  output logic         wrap
);
  localparam logic [W-1:0] F = W'(PWM_INTERVAL);
  localparam logic [W:0] STEP = (W+1)'(DUTY_STEP);
  logic [W-1:0] p, p_nxt;
  logic [W:0] sum;
  logic [2:0] ph_nxt;
  logic [5:0] sel;
  logic tick, stall;
  assign stall = duty_valid && !duty_ready;
  step_timer #(.STEP_INTERVAL(STEP_INTERVAL)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .run(enable),
    .hold(stall),
    .tick(tick)
  );
  function automatic logic [W-1:0] chan(input logic [1:0] c, input logic [W-1:0] pos);
    return c == CH_ZERO ? '0 : c == CH_FULL ? F : c == CH_UP ? pos : F - pos;
  endfunction
  // position and phase a step would produce; a full ramp rolls into the next phase at p=0
  always_comb begin
    sum = {1'b0, p} + STEP;
    p_nxt = p == F ? '0 : (sum >= {1'b0, F} ? F : sum[W-1:0]);
    ph_nxt = p == F ? next_phase(phase) : phase;
    sel = chan_sel(ph_nxt);
  end
  // ramp state, registered triple and handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p <= '0;
      phase <= GREEN_INC;
      duty_r <= F;
      duty_g <= '0;
      duty_b <= '0;
      duty_valid <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= tick && p == F && phase == BLUE_DEC;
      duty_valid <= tick || stall;
      if (tick) begin
        p <= p_nxt;
        phase <= ph_nxt;
        duty_r <= chan(sel[5:4], p_nxt);
        duty_g <= chan(sel[3:2], p_nxt);
        duty_b <= chan(sel[1:0], p_nxt);
      end
    end
endmodule
